ofm_word_packer: RTL

//  Write-side initiator for the packed 32-bit word memory used for layer output dumps.

---
 rtl/ofm_word_packer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ofm_word_packer.sv
// Packs a valid/ready byte stream into 32-bit words (first byte in lane 0 / MSB) and
// drives a word-memory write port, raising done once the frame has been fully written.
module ofm_word_packer #(
    parameter int WIDTH     = 100,
    parameter int NUM_BYTES = 100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     write_en,
    output logic [$clog2(WIDTH)-1:0] addr,
    output logic [0:3][7:0]          out_data,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = $clog2(WIDTH);
    localparam int TW = $clog2(NUM_BYTES + 1);

    generate
        if (NUM_BYTES > WIDTH) begin : g_bad_size
            $error("ofm_word_packer: NUM_BYTES must not exceed WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [0:3][7:0] lanes_q, lanes_d;
    logic [2:0]      lane_cnt_q, lane_cnt_d;
    logic [TW-1:0]   byte_total_q, byte_total_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            final_q, final_d;
    logic [TW-1:0]   byte_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lanes_q      <= '0;
            lane_cnt_q   <= '0;
            byte_total_q <= '0;
            addr_q       <= '0;
            final_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lanes_q      <= lanes_d;
            lane_cnt_q   <= lane_cnt_d;
            byte_total_q <= byte_total_d;
            addr_q       <= addr_d;
            final_q      <= final_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lanes_d      = lanes_q;
        lane_cnt_d   = lane_cnt_q;
        byte_total_d = byte_total_q;
        addr_d       = addr_q;
        final_d      = final_q;
        byte_inc     = byte_total_q + TW'(1);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lanes_d      = '0;
                    lane_cnt_d   = '0;
                    byte_total_d = '0;
                    addr_d       = '0;
                    final_d      = 1'b0;
                    state_d      = S_FILL;
                end
            end
            S_FILL: begin
                if (in_valid) begin
                    lanes_d[lane_cnt_q[1:0]] = in_data;
                    lane_cnt_d               = lane_cnt_q + 3'd1;
                    byte_total_d             = byte_inc;
                    // A word closes on a full lane set, the frame byte limit, or in_last.
                    if (lane_cnt_q == 3'd3 || byte_inc == TW'(NUM_BYTES) || in_last) begin
                        final_d = in_last || (byte_inc == TW'(NUM_BYTES));
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (final_q) begin
                    state_d = S_DONE;
                end else begin
                    addr_d     = addr_q + AW'(4);
                    lanes_d    = '0;
                    lane_cnt_d = '0;
                    state_d    = S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign out_data[gi] = lanes_q[gi];
        end
    endgenerate

    assign addr     = addr_q;
    assign in_ready = (state_q == S_FILL);
    assign write_en = (state_q == S_WRITE);
    assign busy     = (state_q == S_FILL) || (state_q == S_WRITE);
    assign done     = (state_q == S_DONE);
endmodule
